// File: rtl/coin_pkg.sv
// -----------------------------------------------------------------------------
// coin_pkg
// Shared definitions for the coin interface. The coin codes are the same ones
// the coin acceptor uses, so both sides of the machine share this package.
//   COIN_*       : 2-bit coin bus codes, bit 1 = 1 yuan, bit 0 = 5 jiao
//   disp_state_e : dispenser controller states
// -----------------------------------------------------------------------------
package coin_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_HALF = 2'b01;
    localparam logic [1:0] COIN_ONE  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } disp_state_e;

endpackage

// File: rtl/coin_dispenser_if.sv
// -----------------------------------------------------------------------------
// coin_dispenser_if
// Bundle of the change-request handshake, refill pulses, coin bus and status.
//   master : vending-machine controller side (issues requests and refills)
//   slave  : coin dispenser side
// -----------------------------------------------------------------------------
interface coin_dispenser_if #(
    parameter int AMT_W = 4,
    parameter int CNT_W = 6
);
    logic             req_valid;
    logic [AMT_W-1:0] req_amt;
    logic             req_ready;
    logic             refill_one;
    logic             refill_half;
    logic [1:0]       coin_out;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] remain;
    logic [CNT_W-1:0] cnt_one;
    logic [CNT_W-1:0] cnt_half;

    modport master (
        output req_valid, req_amt, refill_one, refill_half,
        input  req_ready, coin_out, done, short, remain, cnt_one, cnt_half
    );

    modport slave (
        input  req_valid, req_amt, refill_one, refill_half,
        output req_ready, coin_out, done, short, remain, cnt_one, cnt_half
    );
endinterface

// File: rtl/coin_dispenser_pulse_timer.sv
// -----------------------------------------------------------------------------
// pulse_timer
// Loadable down-counter with a zero flag. Loading value N makes zero_o rise
// N cycles later; it stays at zero until reloaded.
//   clk, rst_n  : clock, async active-low reset
//   load_i      : load load_val_i this cycle
//   load_val_i  : value to load
//   zero_o      : counter is at zero
// -----------------------------------------------------------------------------
module pulse_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/coin_dispenser.sv
// -----------------------------------------------------------------------------
// coin_dispenser
// Change-return back end. Takes a change amount (0.5-yuan units) over a
// valid/ready handshake and pays it greedily as timed coin pulses: 1-yuan
// coins first, then 5-jiao coins, limited by hopper inventory counters.
//   sys_clk, rst_n : clock, async active-low reset
//   bus (slave)    : request handshake, refill pulses, coin bus, done/short/
//                    remain status and live inventory counts
// -----------------------------------------------------------------------------
module coin_dispenser
    import coin_pkg::*;
#(
    parameter int AMT_W     = 4,
    parameter int CNT_W     = 6,
    parameter int INIT_ONE  = 10,
    parameter int INIT_HALF = 10,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 2
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    coin_dispenser_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int TMR_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    disp_state_e      state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [1:0]       coin_q, coin_d;
    logic             short_q, short_d;
    logic [AMT_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] cnt_one_q, cnt_one_d;
    logic [CNT_W-1:0] cnt_half_q, cnt_half_d;

    logic             dec_one, dec_half;
    logic             tmr_load, tmr_zero;
    logic [TMR_W-1:0] tmr_val;

    // Saturating refill plus single decrement; both in one cycle cancel out.
    function automatic logic [CNT_W-1:0] inv_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (inc && !dec) begin
            if (cnt != CNT_MAX) nxt = cnt + CNT_W'(1);
        end else if (dec && !inc) begin
            nxt = cnt - CNT_W'(1);
        end
        return nxt;
    endfunction

    pulse_timer #(.W(TMR_W)) u_timer (
        .clk        (sys_clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        coin_d   = coin_q;
        short_d  = short_q;
        remain_d = remain_q;
        dec_one  = 1'b0;
        dec_half = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    rem_d   = bus.req_amt;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                // Timer is loaded with length-1 because the load cycle itself
                // is the last SELECT cycle, not part of the pulse.
                if (rem_q >= AMT_W'(2) && cnt_one_q != '0) begin
                    rem_d    = rem_q - AMT_W'(2);
                    dec_one  = 1'b1;
                    coin_d   = COIN_ONE;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(PULSE_LEN - 1);
                    state_d  = ST_PULSE;
                end else if (rem_q != '0 && cnt_half_q != '0) begin
                    rem_d    = rem_q - AMT_W'(1);
                    dec_half = 1'b1;
                    coin_d   = COIN_HALF;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(PULSE_LEN - 1);
                    state_d  = ST_PULSE;
                end else begin
                    short_d  = (rem_q != '0);
                    remain_d = rem_q;
                    state_d  = ST_DONE;
                end
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(GAP_LEN - 1);
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tmr_zero) state_d = ST_SELECT;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        cnt_one_d  = inv_next(cnt_one_q,  bus.refill_one,  dec_one);
        cnt_half_d = inv_next(cnt_half_q, bus.refill_half, dec_half);
    end

    // NOTE: only control/state registers exist here; all get an async reset
    // value so a reset mid-pulse drops the coin bus at once.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            coin_q     <= COIN_NONE;
            short_q    <= 1'b0;
            remain_q   <= '0;
            cnt_one_q  <= CNT_W'(INIT_ONE);
            cnt_half_q <= CNT_W'(INIT_HALF);
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            coin_q     <= coin_d;
            short_q    <= short_d;
            remain_q   <= remain_d;
            cnt_one_q  <= cnt_one_d;
            cnt_half_q <= cnt_half_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.coin_out  = (state_q == ST_PULSE) ? coin_q : COIN_NONE;
    assign bus.short     = short_q;
    assign bus.remain    = remain_q;
    assign bus.cnt_one   = cnt_one_q;
    assign bus.cnt_half  = cnt_half_q;

endmodule

// File: doc/coin_dispenser.md
Name: coin_dispenser

Overview:
- Change-return back end of the vending machine. Accepts a change amount in half-yuan units over a valid/ready handshake.
- Pays the amount as timed coin pulses on a 2-bit coin bus, using the same [1 yuan, 5 jiao] encoding as the coin-acceptor input. This is the transmit direction of that coin interface.
- Greedy selection: 1-yuan coins first, then 5-jiao coins, bounded by on-chip hopper inventory counters.
- Reports completion, shortfall and any unpaid remainder.

Parameters:
- AMT_W, 4: width of request amount and remainder, in 0.5-yuan units.
- CNT_W, 6: width of each hopper inventory counter.
- INIT_ONE, 10: 1-yuan coin count loaded at reset.
- INIT_HALF, 10: 5-jiao coin count loaded at reset.
- PULSE_LEN, 4: cycles coin_out is held per coin (>=1).
- GAP_LEN, 2: idle cycles after each coin (>=1).

Ports:
- sys_clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  change request valid.
- req_amt  in  AMT_W  requested change, 0.5-yuan units.
- req_ready  out  1  high only in IDLE.
- refill_one  in  1  single-cycle pulse: one 1-yuan coin added to hopper.
- refill_half  in  1  single-cycle pulse: one 5-jiao coin added to hopper.
- coin_out  out  2  [1 yuan, 5 jiao]; 10 = eject 1 yuan, 01 = eject 5 jiao, 00 = none.
- done  out  1  one-cycle completion pulse.
- short  out  1  valid with done: hopper could not cover the full amount.
- remain  out  AMT_W  valid with done: unpaid amount (0 when short=0).
- cnt_one  out  CNT_W  current 1-yuan inventory.
- cnt_half  out  CNT_W  current 5-jiao inventory.

Behaviour:
- Reset (async, rst_n low):
  - State = IDLE.
  - coin_out=00, done=0, short=0, remain=0.
  - cnt_one=INIT_ONE, cnt_half=INIT_HALF.
  - Any in-flight request is abandoned, including mid-pulse; coin_out drops to 00 immediately.
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE:
  - req_ready=1.
  - Transfer occurs when req_valid=1 and req_ready=1. req_amt is latched into the internal remainder rem, next state SELECT.
  - req_amt=0 still passes through SELECT and completes with done=1, short=0.
- SELECT (one cycle, coin_out=00):
  - If rem>=2 and cnt_one>0: rem-=2, cnt_one-=1, coin=ONE, next PULSE.
  - Else if rem>=1 and cnt_half>0: rem-=1, cnt_half-=1, coin=HALF, next PULSE.
  - Else next DONE, with short=(rem!=0) and remain=rem.
  - Greedy fallback: with rem>=2 and cnt_one=0, 5-jiao coins are paid one at a time.
- PULSE:
  - coin_out = selected code for exactly PULSE_LEN cycles, then GAP.
  - coin_out is never 11.
- GAP: coin_out=00 for GAP_LEN cycles, then SELECT.
- DONE: done=1 for exactly one cycle, with short/remain valid; next IDLE.
- short and remain hold their last values until the next DONE. Only the done pulse qualifies them.
- Latency: transfer at cycle T gives SELECT at T+1 and the first coin_out cycle at T+2.
- Inventory counters:
  - Decrement occurs only on the SELECT->PULSE edge.
  - A refill pulse increments the counter, saturating at 2^CNT_W-1.
  - Refill and decrement of the same counter in the same cycle: net unchanged.
  - Refills are accepted in every state.
- req_valid and req_amt are ignored outside IDLE.

Decomposition:
- Shared package coin_pkg:
  - Coin-bus codes: COIN_NONE=2'b00, COIN_HALF=2'b01, COIN_ONE=2'b10. These are shared with the coin-acceptor side.
  - Dispenser state encoding constants.
- One natural sub-module: pulse_timer. A loadable down-counter with zero flag, used for both PULSE_LEN and GAP_LEN timing.
- Inventory counters stay inline.

Test Plan (all with default parameters):
- Reset: hold rst_n=0 -> coin_out=00, done=0, req_ready=1, cnt_one=10, cnt_half=10.
- Exact pay: req_amt=3 accepted at cycle 0 ->
  - coin_out=10 in cycles 2-5, 00 in 6-8, 01 in 9-12.
  - done=1 at cycle 16 with short=0, remain=0.
  - cnt_one=9, cnt_half=9; req_ready=1 again at cycle 17.
- Fallback: preset cnt_one=0 via reset-init override, req_amt=2 -> two 01 pulses, done with short=0, cnt_half decreases by 2.
- Shortfall: drain to cnt_one=0, cnt_half=1, then req_amt=4 -> one 01 pulse, done with short=1, remain=3, cnt_half=0.
- Refill collision: refill_one pulsed in the same cycle as the SELECT->PULSE decrement of a 1-yuan coin -> cnt_one unchanged. Refill at cnt_one=63 -> stays 63.
- Reset mid-pulse: assert rst_n=0 during the 2nd cycle of a 10 pulse -> coin_out=00 immediately, no done. After release, state IDLE and counters at INIT values.
